mod_updown_counter_jk: RTL and testbench

MOD_UPDOWN_COUNTER_JK -- requirements
Module: mod_updown_counter_jk

---
 rtl/counter_defs.sv | 10 +
 rtl/jk_ff.sv | 24 ++
 rtl/mod_updown_counter_jk.sv | 87 ++++++++
 tb/tb_mod_updown_counter_jk.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/counter_defs.sv
// Shared defaults and direction encoding for the modulo up/down counter.
package counter_defs;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-low clear.
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle; reset clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/mod_updown_counter_jk.sv
// Modulo-N up/down counter built from JK flip-flops, with parallel load,
// optional saturation at the range ends, terminal count and wrap pulse.
module mod_updown_counter_jk
  import counter_defs::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  // MODULUS may equal 2**WIDTH, so the clamp compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] next_q;
  logic             wrap_next;

  // Next count: load (clamped) beats count enable; ends wrap or saturate.
  always_comb begin
    next_q    = q;
    wrap_next = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= MOD_EXT) begin
        next_q = MAX_Q;
      end else begin
        next_q = load_val;
      end
    end else if (en) begin
      if (up_dn == UP) begin
        if (q == MAX_Q) begin
          if (SATURATE != 0) begin
            next_q = q;
          end else begin
            next_q    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          next_q = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          if (SATURATE != 0) begin
            next_q = q;
          end else begin
            next_q    = MAX_Q;
            wrap_next = 1'b1;
          end
        end else begin
          next_q = q - WIDTH'(1);
        end
      end
    end
  end

  // One JK flip-flop per bit; J sets bits that must rise, K clears bits that must fall.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_jk (
      .clk   (clk),
      .reset (reset),
      .j     (next_q[i] & ~q[i]),
      .k     (~next_q[i] & q[i]),
      .q     (q[i])
    );
  end

  assign tc = ((up_dn == UP) && (q == MAX_Q)) || ((up_dn == DOWN) && (q == '0));

  // Wrap pulse register: high for the cycle after a wrap-around edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter_jk.sv
// Directed bench for mod_updown_counter_jk: a wrapping instance and a
// saturating instance share the same stimulus.
module tb_mod_updown_counter_jk;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q0, q1;
  logic         tc0, tc1, wrap0, wrap1;

  int checks   = 0;
  int failures = 0;

  mod_updown_counter_jk #(.WIDTH(W), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0)
  );

  mod_updown_counter_jk #(.WIDTH(W), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    tick();
    tick();
    // Reset state
    check("rst_q0", 32'(q0), 0);
    check("rst_q1", 32'(q1), 0);
    check("rst_wrap0", 32'(wrap0), 0);
    check("rst_tc0_up", 32'(tc0), 0);

    // Count up 12 edges from 0
    reset = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_q0_%0d", i), 32'(q0), 32'(i % 10));
      check($sformatf("up_wrap0_%0d", i), 32'(wrap0), (i == 10) ? 32'd1 : 32'd0);
      check($sformatf("up_tc0_%0d", i), 32'(tc0), (i == 9) ? 32'd1 : 32'd0);
      check($sformatf("up_q1_%0d", i), 32'(q1), (i < 9) ? 32'(i) : 32'd9);
      check($sformatf("up_wrap1_%0d", i), 32'(wrap1), 0);
    end

    // Reset mid-count, then count down
    reset = 1'b0;
    tick();
    check("rst2_q0", 32'(q0), 0);
    reset = 1'b1; up_dn = 1'b0;
    #1;
    check("dn_tc0_at0", 32'(tc0), 1);
    tick();
    check("dn_q0_a", 32'(q0), 9);
    check("dn_wrap0_a", 32'(wrap0), 1);
    check("dn_q1_a", 32'(q1), 0);
    check("dn_wrap1_a", 32'(wrap1), 0);
    tick();
    check("dn_q0_b", 32'(q0), 8);
    check("dn_wrap0_b", 32'(wrap0), 0);
    tick();
    check("dn_q0_c", 32'(q0), 7);

    // Load beats enable; out-of-range load clamps
    load = 1'b1; load_val = 4'd6; up_dn = 1'b1;
    tick();
    check("ld6_q0", 32'(q0), 6);
    check("ld6_q1", 32'(q1), 6);
    check("ld6_wrap0", 32'(wrap0), 0);
    load_val = 4'd13;
    tick();
    check("ld13_q0", 32'(q0), 9);
    check("ld13_q1", 32'(q1), 9);
    check("ld13_wrap0", 32'(wrap0), 0);

    // Saturating instance: up from 7 for 5 edges
    load_val = 4'd7;
    tick();
    load = 1'b0; load_val = '0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat_up_q1_%0d", i), 32'(q1), (i == 1) ? 32'd8 : 32'd9);
      check($sformatf("sat_up_wrap1_%0d", i), 32'(wrap1), 0);
      check($sformatf("sat_up_q0_%0d", i), 32'(q0), 32'((7 + i) % 10));
      check($sformatf("sat_up_wrap0_%0d", i), 32'(wrap0), (i == 3) ? 32'd1 : 32'd0);
    end
    check("sat_tc1_at9", 32'(tc1), 1);

    // Saturating instance: down from 1
    load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0; up_dn = 1'b0;
    tick();
    check("sat_dn_q1_a", 32'(q1), 0);
    check("sat_dn_q0_a", 32'(q0), 0);
    tick();
    check("sat_dn_q1_b", 32'(q1), 0);
    check("sat_dn_wrap1_b", 32'(wrap1), 0);
    check("sat_dn_q0_b", 32'(q0), 9);
    check("sat_dn_wrap0_b", 32'(wrap0), 1);

    // Reset overrides load and enable
    load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
    tick();
    check("pre_rst_q0", 32'(q0), 5);
    reset = 1'b0; load = 1'b1; en = 1'b1;
    tick();
    check("rst_over_q0", 32'(q0), 0);
    check("rst_over_wrap0", 32'(wrap0), 0);
    reset = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("rst_rel_q0", 32'(q0), 1);

    // Enable toggling with a direction flip at 4
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("tog_q0_1", 32'(q0), 5);
    en = 1'b0;
    tick();
    check("tog_q0_2", 32'(q0), 5);
    en = 1'b1; up_dn = 1'b0;
    tick();
    check("tog_q0_3", 32'(q0), 4);
    en = 1'b0;
    tick();
    check("tog_q0_4", 32'(q0), 4);
    check("hold_wrap0", 32'(wrap0), 0);
    en = 1'b1;
    tick();
    check("tog_q0_5", 32'(q0), 3);

    // Terminal count follows direction and ignores enable
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    #1;
    check("tc0_up_q9", 32'(tc0), 1);
    up_dn = 1'b0;
    #1;
    check("tc0_dn_q9", 32'(tc0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
